alu_writeback: RTL and testbench
================================

ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 Parameter: DEPTH, 2, result-queue entries (power of two, >=2).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 in_valid  in  1  ALU result present this cycle.
REQ-005 in_ready  out  1  block can accept; = (count < DEPTH).
REQ-006 alu_sel  in  4  opcode that produced the result.
REQ-007 dest  in  3  destination register index.
REQ-008 alu_c  in  8  ALU result C.
REQ-009 alu_flags  in  7  ALU flags {S,C,Z,P,O,I,D}, bit 6..0.
REQ-010 alu_cmp  in  2  comparison code (00 eq, 01 gt, 10 lt).
REQ-011 wr_valid  out  1  register-file write pending.
REQ-012 wr_ready  in  1  register file accepts write.
REQ-013 wr_addr  out  3  write index (head entry).
REQ-014 wr_data  out  8  write data (head entry).
REQ-015 flags_q  out  7  architectural flags register.
REQ-016 cmp_q  out  2  last comparison code.
REQ-017 err_div0  out  1  sticky division/modulo-by-zero error.
REQ-018 err_ill  out  1  sticky illegal-opcode error.
REQ-019 err_clr  in  1  synchronous clear of both sticky errors.

Function
REQ-020 Accept = in_valid & in_ready; nothing changes on non-accept cycles except dequeue and err_clr.
REQ-021 On accept, flags_q <= alu_flags for every opcode 0x0-0xD, including compare and div-by-zero.
REQ-022 Opcodes 0x0-0x4, 0x6-0xD with valid result: push {dest, alu_c} into queue.
REQ-023 Opcode 0x5 (compare): cmp_q <= alu_cmp; no push.
REQ-024 Opcode 0x3/0x4 with alu_c==8'hFF and alu_flags==7'h7F: err_div0 <= 1; no push.
REQ-025 Opcodes 0xE, 0xF: err_ill <= 1; flags_q, cmp_q unchanged; no push.
REQ-026 Dequeue = wr_valid & wr_ready; wr_valid = (count != 0); wr_addr/wr_data driven from registered head entry.
REQ-027 Latency: result accepted at edge N appears on wr_* after edge N (visible in cycle N+1); no combinational in-to-out bypass.
REQ-028 Push and dequeue in same cycle: count unchanged, order preserved (FIFO).
REQ-029 Full (count==DEPTH): in_ready=0; inputs ignored regardless of in_valid.
REQ-030 Pointers wrap modulo DEPTH; count width log2(DEPTH)+1.
REQ-031 err_clr with simultaneous new error: set wins.
REQ-032 wr_addr/wr_data stable while wr_valid=1 and wr_ready=0.

Reset
REQ-033 rst_n low: count=0, pointers=0, wr_valid=0, wr_addr=0, wr_data=0, flags_q=0, cmp_q=0, err_div0=0, err_ill=0, in_ready=1.
REQ-034 Reset mid-operation discards queued entries; no write issued after release until a new accept.

Structure
REQ-035 Shared package holds opcode constants (ADD..XNOR = 0x0..0xD), flag bit indices, comparison codes, DIV0 signature values.
REQ-036 One sub-module: wb_fifo (parameterised DEPTH x 11-bit FIFO, push/pop/count); classification logic stays in alu_writeback.

Verification
REQ-037 ADD, dest=3, C=0x2A, flags=0x08, wr_ready=1 -> next cycle wr_valid=1, wr_addr=3, wr_data=0x2A; flags_q=0x08.
REQ-038 Compare, cmp=01 -> cmp_q=01, wr_valid stays 0.
REQ-039 DIV, C=0xFF, flags=0x7F -> err_div0=1, flags_q=0x7F, no write; err_clr -> err_div0=0.
REQ-040 wr_ready=0, three back-to-back results (0x11,0x22,0x33) -> third stalled (in_ready=0); release -> writes 0x11,0x22,0x33 in order.
REQ-041 Opcode 0xE -> err_ill=1, flags_q unchanged; assert rst_n with two queued entries -> all outputs zero, queue empty.

Source files
------------

// File: rtl/alu_writeback_pkg.sv
// Shared definitions for the ALU writeback slice.
// Holds the opcode map, the flag bit positions inside the 7-bit flag word,
// the comparison codes, the signature of a division/modulo-by-zero result,
// and a small opcode classification helper.
package alu_writeback_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_MUL  = 4'h2,
    OP_DIV  = 4'h3,
    OP_MOD  = 4'h4,
    OP_CMP  = 4'h5,
    OP_AND  = 4'h6,
    OP_OR   = 4'h7,
    OP_XOR  = 4'h8,
    OP_NOT  = 4'h9,
    OP_SHL  = 4'hA,
    OP_SHR  = 4'hB,
    OP_NAND = 4'hC,
    OP_XNOR = 4'hD
  } alu_op_e;

  // Flag word layout {S,C,Z,P,O,I,D}, bit 6 down to bit 0
  localparam int FLAG_S = 6;
  localparam int FLAG_C = 5;
  localparam int FLAG_Z = 4;
  localparam int FLAG_P = 3;
  localparam int FLAG_O = 2;
  localparam int FLAG_I = 1;
  localparam int FLAG_D = 0;

  localparam logic [1:0] CMP_EQ = 2'b00;
  localparam logic [1:0] CMP_GT = 2'b01;
  localparam logic [1:0] CMP_LT = 2'b10;

  // The ALU signals a zero divisor with an all-ones result and all flags set
  localparam logic [7:0] DIV0_C     = 8'hFF;
  localparam logic [6:0] DIV0_FLAGS = 7'h7F;

  // Queue entry is {dest[2:0], data[7:0]}
  localparam int WB_ENTRY_W = 11;

  // Opcodes above XNOR (0xE, 0xF) have no defined operation
  function automatic logic is_illegal_op(input logic [3:0] sel);
    return sel > 4'(OP_XNOR);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding pending register-file writes.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push, push_data write one entry (caller guarantees not full)
//   pop             remove the head entry (caller guarantees not empty)
//   head_data       registered head entry
//   count           number of stored entries, 0..DEPTH
// Storage is cleared on reset so the head reads zero until the first push.
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 11
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage: classifies each ALU result, updates the architectural
// flags / comparison registers and sticky error bits, and queues register
// writes for the register file.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   in_valid/in_ready                  ALU result handshake (ready = not full)
//   alu_sel, dest, alu_c, alu_flags, alu_cmp   result fields
//   wr_valid/wr_ready, wr_addr, wr_data        register-file write handshake
//   flags_q, cmp_q                     architectural flag / compare registers
//   err_div0, err_ill, err_clr         sticky errors and their clear
module alu_writeback
  import alu_writeback_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] alu_sel,
  input  logic [2:0] dest,
  input  logic [7:0] alu_c,
  input  logic [6:0] alu_flags,
  input  logic [1:0] alu_cmp,
  output logic       wr_valid,
  input  logic       wr_ready,
  output logic [2:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [6:0] flags_q,
  output logic [1:0] cmp_q,
  output logic       err_div0,
  output logic       err_ill,
  input  logic       err_clr
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]         count;
  logic [WB_ENTRY_W-1:0] head;
  logic                  accept;
  logic                  op_ill;
  logic                  op_cmp;
  logic                  op_div0;
  logic                  push;
  logic                  pop;

  // Input classification
  assign in_ready = (count < CW'(DEPTH));
  assign accept   = in_valid & in_ready;
  assign op_ill   = is_illegal_op(alu_sel);
  assign op_cmp   = (alu_sel == 4'(OP_CMP));
  assign op_div0  = ((alu_sel == 4'(OP_DIV)) || (alu_sel == 4'(OP_MOD)))
                    && (alu_c == DIV0_C) && (alu_flags == DIV0_FLAGS);
  assign push     = accept & ~op_ill & ~op_cmp & ~op_div0;
  assign pop      = wr_valid & wr_ready;

  wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WB_ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({dest, alu_c}),
    .pop       (pop),
    .head_data (head),
    .count     (count)
  );

  // Write port driven straight from the registered head entry
  assign wr_valid           = (count != '0);
  assign {wr_addr, wr_data} = head;

  // Architectural state; a newly detected error wins over err_clr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q  <= '0;
      cmp_q    <= '0;
      err_div0 <= 1'b0;
      err_ill  <= 1'b0;
    end else begin
      if (accept && !op_ill) flags_q <= alu_flags;
      if (accept && op_cmp)  cmp_q   <= alu_cmp;

      if (accept && op_div0)  err_div0 <= 1'b1;
      else if (err_clr)       err_div0 <= 1'b0;

      if (accept && op_ill)   err_ill <= 1'b1;
      else if (err_clr)       err_ill <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_writeback.sv
// Testbench for alu_writeback: directed scenarios followed by random traffic,
// all compared against a queue-based reference model.
module tb_alu_writeback;
  import alu_writeback_pkg::*;

  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] alu_sel = '0;
  logic [2:0] dest = '0;
  logic [7:0] alu_c = '0;
  logic [6:0] alu_flags = '0;
  logic [1:0] alu_cmp = '0;
  logic       wr_valid;
  logic       wr_ready = 1'b0;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic [6:0] flags_q;
  logic [1:0] cmp_q;
  logic       err_div0;
  logic       err_ill;
  logic       err_clr = 1'b0;

  alu_writeback #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_sel   (alu_sel),
    .dest      (dest),
    .alu_c     (alu_c),
    .alu_flags (alu_flags),
    .alu_cmp   (alu_cmp),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .flags_q   (flags_q),
    .cmp_q     (cmp_q),
    .err_div0  (err_div0),
    .err_ill   (err_ill),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [10:0] m_q[$];
  logic [6:0]  m_flags;
  logic [1:0]  m_cmp;
  logic        m_div0;
  logic        m_ill;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_flags = '0;
    m_cmp   = '0;
    m_div0  = 1'b0;
    m_ill   = 1'b0;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".in_ready"}, in_ready, (m_q.size() < DEPTH));
    check({tag, ".wr_valid"}, wr_valid, (m_q.size() != 0));
    check({tag, ".flags_q"}, flags_q, m_flags);
    check({tag, ".cmp_q"}, cmp_q, m_cmp);
    check({tag, ".err_div0"}, err_div0, m_div0);
    check({tag, ".err_ill"}, err_ill, m_ill);
    if (m_q.size() != 0) begin
      check({tag, ".wr_addr"}, wr_addr, m_q[0][10:8]);
      check({tag, ".wr_data"}, wr_data, m_q[0][7:0]);
    end
  endtask

  // Called at a falling edge: drive inputs, advance the model by one clock,
  // then compare at the next falling edge.
  task automatic step(input string tag, input logic iv, input logic [3:0] sel,
                      input logic [2:0] d, input logic [7:0] c, input logic [6:0] fl,
                      input logic [1:0] cm, input logic wrr, input logic clr);
    bit can_take;
    in_valid = iv; alu_sel = sel; dest = d; alu_c = c; alu_flags = fl;
    alu_cmp = cm; wr_ready = wrr; err_clr = clr;

    can_take = iv && (m_q.size() < DEPTH);
    if (wrr && m_q.size() != 0) void'(m_q.pop_front());
    if (clr) begin
      m_div0 = 1'b0;
      m_ill  = 1'b0;
    end
    if (can_take) begin
      if (sel >= 4'hE) begin
        m_ill = 1'b1;
      end else begin
        m_flags = fl;
        if (sel == 4'h5)
          m_cmp = cm;
        else if ((sel == 4'h3 || sel == 4'h4) && c == 8'hFF && fl == 7'h7F)
          m_div0 = 1'b1;
        else
          m_q.push_back({d, c});
      end
    end

    @(negedge clk);
    check_model(tag);
  endtask

  task automatic idle(input string tag, input logic wrr);
    step(tag, 1'b0, 4'h0, 3'd0, 8'h00, 7'h00, 2'b00, wrr, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".in_ready"}, in_ready, 1'b1);
    check({tag, ".wr_valid"}, wr_valid, 1'b0);
    check({tag, ".wr_addr"}, wr_addr, 3'd0);
    check({tag, ".wr_data"}, wr_data, 8'h00);
    check({tag, ".flags_q"}, flags_q, 7'h00);
    check({tag, ".cmp_q"}, cmp_q, 2'b00);
    check({tag, ".err_div0"}, err_div0, 1'b0);
    check({tag, ".err_ill"}, err_ill, 1'b0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Single ADD written back the next cycle
    step("add", 1'b1, 4'h0, 3'd3, 8'h2A, 7'h08, 2'b00, 1'b1, 1'b0);
    check("add.wr_valid_k", wr_valid, 1'b1);
    check("add.wr_addr_k", wr_addr, 3'd3);
    check("add.wr_data_k", wr_data, 8'h2A);
    check("add.flags_k", flags_q, 7'h08);
    idle("add_drain", 1'b1);
    check("add_drain.wr_valid_k", wr_valid, 1'b0);

    // Compare updates cmp_q only
    step("cmp", 1'b1, 4'h5, 3'd1, 8'h55, 7'h10, 2'b01, 1'b1, 1'b0);
    check("cmp.cmp_k", cmp_q, 2'b01);
    check("cmp.wr_valid_k", wr_valid, 1'b0);

    // Division by zero, then clear
    step("div0", 1'b1, 4'h3, 3'd2, 8'hFF, 7'h7F, 2'b00, 1'b1, 1'b0);
    check("div0.err_k", err_div0, 1'b1);
    check("div0.flags_k", flags_q, 7'h7F);
    check("div0.wr_valid_k", wr_valid, 1'b0);
    step("div0_clr", 1'b0, 4'h0, 3'd0, 8'h00, 7'h00, 2'b00, 1'b1, 1'b1);
    check("div0_clr.err_k", err_div0, 1'b0);

    // Set beats clear in the same cycle
    step("div0_setwin", 1'b1, 4'h4, 3'd2, 8'hFF, 7'h7F, 2'b00, 1'b1, 1'b1);
    check("div0_setwin.err_k", err_div0, 1'b1);
    idle("div0_clr2", 1'b1);
    step("div0_clr3", 1'b0, 4'h0, 3'd0, 8'h00, 7'h00, 2'b00, 1'b1, 1'b1);

    // Back-pressure: third result stalls, then drains in order
    step("bp1", 1'b1, 4'h1, 3'd1, 8'h11, 7'h01, 2'b00, 1'b0, 1'b0);
    step("bp2", 1'b1, 4'h6, 3'd2, 8'h22, 7'h02, 2'b00, 1'b0, 1'b0);
    check("bp2.in_ready_k", in_ready, 1'b0);
    step("bp3", 1'b1, 4'h7, 3'd3, 8'h33, 7'h03, 2'b00, 1'b0, 1'b0);
    check("bp3.in_ready_k", in_ready, 1'b0);
    check("bp3.wr_data_k", wr_data, 8'h11);
    check("bp3.flags_k", flags_q, 7'h02);
    step("bp4", 1'b1, 4'h7, 3'd3, 8'h33, 7'h03, 2'b00, 1'b1, 1'b0);
    check("bp4.wr_data_k", wr_data, 8'h22);
    step("bp5", 1'b1, 4'h7, 3'd3, 8'h33, 7'h03, 2'b00, 1'b1, 1'b0);
    check("bp5.wr_data_k", wr_data, 8'h33);
    idle("bp6", 1'b1);
    check("bp6.wr_valid_k", wr_valid, 1'b0);

    // Illegal opcode keeps flags
    step("ill", 1'b1, 4'hE, 3'd5, 8'h99, 7'h55, 2'b10, 1'b1, 1'b0);
    check("ill.err_k", err_ill, 1'b1);
    check("ill.flags_k", flags_q, 7'h03);
    check("ill.wr_valid_k", wr_valid, 1'b0);

    // Reset with two queued entries
    step("prerst1", 1'b1, 4'h2, 3'd4, 8'h44, 7'h04, 2'b00, 1'b0, 1'b0);
    step("prerst2", 1'b1, 4'h8, 3'd5, 8'h55, 7'h05, 2'b00, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    idle("postrst", 1'b1);
    check("postrst.wr_valid_k", wr_valid, 1'b0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [3:0] sel;
      logic [7:0] c;
      logic [6:0] fl;
      sel = 4'($urandom_range(0, 15));
      c   = 8'($urandom);
      fl  = 7'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        sel = ($urandom_range(0, 1) == 0) ? 4'h3 : 4'h4;
        c   = 8'hFF;
        fl  = 7'h7F;
      end
      step("rand", 1'($urandom_range(0, 3) != 0), sel, 3'($urandom), c, fl,
           2'($urandom_range(0, 2)), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 7) == 0));
      if (i == 200) begin
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all_zero("randrst");
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
